// File: rtl/shared_adder_arbiter_if.sv
// Request/operand/result bundle between two requesters and the shared adder.
// The master side drives requests and operands; the slave side is the arbiter.
interface shared_adder_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             cin0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             cin1;
   logic             gnt0;
   logic             gnt1;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH:0]   shl;

   modport master (
      output req0, a0, b0, cin0, req1, a1, b1, cin1,
      input  gnt0, gnt1, busy, done, done_id, sum, cout, shl
   );

   modport slave (
      input  req0, a0, b0, cin0, req1, a1, b1, cin1,
      output gnt0, gnt1, busy, done, done_id, sum, cout, shl
   );
endinterface

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one registered add/shift datapath between two requesters.
// state | meaning
// IDLE  | waiting for a request; grants on the edge a request is seen
// BUSY  | operation in flight, cnt counts down LAT-1..0, result loads at 0
// DONE  | result valid pulse next cycle, round-robin pointer flips to the other requester
module shared_adder_arbiter #(
   parameter int WIDTH = 4,
   parameter int LAT   = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   shared_adder_arbiter_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   logic [1:0]       state     = IDLE;
   logic [3:0]       cnt       = '0;
   logic             rr_ptr    = 1'b0;
   logic             owner     = 1'b0;
   logic [WIDTH-1:0] a_q       = '0;
   logic [WIDTH-1:0] b_q       = '0;
   logic             cin_q     = 1'b0;
   logic             gnt0_q    = 1'b0;
   logic             gnt1_q    = 1'b0;
   logic             busy_q    = 1'b0;
   logic             done_q    = 1'b0;
   logic             done_id_q = 1'b0;
   logic [WIDTH-1:0] sum_q     = '0;
   logic             cout_q    = 1'b0;
   logic [WIDTH:0]   shl_q     = '0;

   logic             pick;
   logic [WIDTH:0]   full;

   always_comb begin
      pick = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
      full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         shl_q     <= '0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  owner  <= pick;
                  a_q    <= pick ? bus.a1 : bus.a0;
                  b_q    <= pick ? bus.b1 : bus.b0;
                  cin_q  <= pick ? bus.cin1 : bus.cin0;
                  gnt0_q <= !pick;
                  gnt1_q <= pick;
                  cnt    <= CNT_INIT;
                  busy_q <= 1'b1;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  {cout_q, sum_q} <= full;
                  shl_q           <= {full[WIDTH-1:0], 1'b0};
                  done_id_q       <= owner;
                  state           <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               rr_ptr <= ~owner;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
   assign bus.shl     = shl_q;

`ifdef FORMAL
   logic       past_valid = 1'b0;
   logic [1:0] state_d1   = IDLE;
   logic [1:0] state_d2   = IDLE;

   always_ff @(posedge clk) begin
      past_valid <= 1'b1;
      state_d1   <= state;
      state_d2   <= state_d1;
   end

   // done is registered out of DONE, so the BUSY state sits two cycles back
   always_comb begin
      if (!past_valid) begin
         assume (!rst_n);
         assert (state == IDLE);
         assert (!gnt0_q && !gnt1_q && !busy_q && !done_q && !done_id_q);
         assert (sum_q == '0 && !cout_q && shl_q == '0);
      end
      assert (!(gnt0_q && gnt1_q));
      assert (busy_q == (state != IDLE));
      assert (int'(cnt) < LAT);
      if (done_q) assert (state_d2 == BUSY);
   end

   always_ff @(posedge clk) begin
      if (past_valid && $past(bus.req0 && !bus.gnt0)) assume (bus.req0);
      if (past_valid && $past(bus.req1 && !bus.gnt1)) assume (bus.req1);
   end
`endif
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench: cycle model of grant/busy/done plus a result scoreboard.
module tb_shared_adder_arbiter;
   localparam int WIDTH = 4;
   localparam int LAT   = 2;

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic [WIDTH:0]   shl;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shared_adder_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

   shared_adder_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   int   m_phase = 0;
   logic m_rr    = 1'b0;
   logic m_id    = 1'b0;
   logic m_gnt0  = 1'b0;
   logic m_gnt1  = 1'b0;
   logic m_done  = 1'b0;
   logic m_busy  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t calc(input logic id, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic cin);
      exp_t e;
      int   t;
      int   s2;
      t      = int'(a) + int'(b) + int'(cin);
      s2     = (t * 2) % (1 << (WIDTH + 1));
      e.id   = id;
      e.sum  = t[WIDTH-1:0];
      e.cout = t[WIDTH];
      e.shl  = s2[WIDTH:0];
      return e;
   endfunction

   // reference model: phase counts cycles since the grant edge
   always @(posedge clk) begin
      m_gnt0 = 1'b0;
      m_gnt1 = 1'b0;
      m_done = 1'b0;
      if (!rst_n) begin
         m_phase = 0;
         m_rr    = 1'b0;
         sb_q.delete();
      end else if (m_phase == 0) begin
         if (bus_if.req0 || bus_if.req1) begin
            m_id = (bus_if.req0 && bus_if.req1) ? m_rr : bus_if.req1;
            if (m_id) begin
               m_gnt1 = 1'b1;
               sb_q.push_back(calc(1'b1, bus_if.a1, bus_if.b1, bus_if.cin1));
            end else begin
               m_gnt0 = 1'b1;
               sb_q.push_back(calc(1'b0, bus_if.a0, bus_if.b0, bus_if.cin0));
            end
            m_phase = 1;
         end
      end else if (m_phase == LAT + 1) begin
         m_done  = 1'b1;
         m_rr    = ~m_id;
         m_phase = 0;
      end else begin
         m_phase++;
      end
      m_busy = (m_phase != 0);
   end

   always @(negedge clk) begin
      exp_t e;
      chk("gnt0", 32'(bus_if.gnt0), 32'(m_gnt0));
      chk("gnt1", 32'(bus_if.gnt1), 32'(m_gnt1));
      chk("busy", 32'(bus_if.busy), 32'(m_busy));
      chk("done", 32'(bus_if.done), 32'(m_done));
      if (bus_if.done) begin
         chk("sb_avail", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("done_id", 32'(bus_if.done_id), 32'(e.id));
            chk("sum",     32'(bus_if.sum),     32'(e.sum));
            chk("cout",    32'(bus_if.cout),    32'(e.cout));
            chk("shl",     32'(bus_if.shl),     32'(e.shl));
         end
      end
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_sum"},     32'(bus_if.sum),     32'd0);
      chk({tag, "_cout"},    32'(bus_if.cout),    32'd0);
      chk({tag, "_shl"},     32'(bus_if.shl),     32'd0);
      chk({tag, "_done_id"}, 32'(bus_if.done_id), 32'd0);
   endtask

   task automatic set_ops(input logic id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin);
      if (id) begin
         bus_if.a1 = a; bus_if.b1 = b; bus_if.cin1 = cin;
      end else begin
         bus_if.a0 = a; bus_if.b0 = b; bus_if.cin0 = cin;
      end
   endtask

   task automatic scramble_ops();
      set_ops(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      set_ops(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
   endtask

   // raise req, hold until the model grants, drop it, then disturb operands
   task automatic single(input logic id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
      int seen;
      @(negedge clk);
      set_ops(id, a, b, cin);
      if (id) bus_if.req1 = 1'b1; else bus_if.req0 = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge clk);
         if ((id && m_gnt1) || (!id && m_gnt0)) seen = 1;
      end
      chk("grant_seen", 32'(seen), 32'd1);
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      scramble_ops();
      repeat (LAT + 3) @(negedge clk);
   endtask

   initial begin
      bus_if.req0 = 1'b1;
      bus_if.req1 = 1'b1;
      set_ops(1'b0, 4'd5, 4'd9, 1'b0);
      set_ops(1'b1, 4'd7, 4'd2, 1'b1);

      // reset hold with both requests asserted
      repeat (3) begin
         @(negedge clk);
         chk_zero_outputs("rst");
      end
      rst_n = 1'b1;

      // contention with operands changing every cycle
      repeat (5 * (LAT + 2)) begin
         @(negedge clk);
         scramble_ops();
      end
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      single(1'b0, 4'd3, 4'd4, 1'b1);
      single(1'b1, 4'd15, 4'd15, 1'b1);
      single(1'b0, 4'd0, 4'd0, 1'b0);
      single(1'b1, 4'd15, 4'd0, 1'b1);
      single(1'b0, 4'd8, 4'd8, 1'b0);

      // late request: req1 rises while req0's operation is busy, req0 stays high
      @(negedge clk);
      set_ops(1'b0, 4'd6, 4'd5, 1'b0);
      set_ops(1'b1, 4'd9, 4'd9, 1'b0);
      bus_if.req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_if.req1 = 1'b1;
      bus_if.a0   = 4'd1;
      repeat (3 * (LAT + 2)) @(negedge clk);
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      // mid-operation reset during req1's op, rr would otherwise favour req1
      single(1'b0, 4'd2, 4'd2, 1'b0);
      @(negedge clk);
      set_ops(1'b1, 4'd12, 4'd3, 1'b1);
      bus_if.req1 = 1'b1;
      @(negedge clk);
      bus_if.req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero_outputs("midrst");
      rst_n = 1'b1;
      bus_if.req0 = 1'b1;
      bus_if.req1 = 1'b1;
      set_ops(1'b0, 4'd10, 4'd11, 1'b1);
      @(negedge clk);
      chk("tie_after_rst", 32'(bus_if.gnt0), 32'd1);
      bus_if.req0 = 1'b0;
      repeat (2 * (LAT + 2)) @(negedge clk);
      bus_if.req1 = 1'b0;
      repeat (2 * (LAT + 3)) @(negedge clk);

      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
